apb_initiator: RTL and testbench

Synchronous APB3 initiator that converts a simple valid/ready command stream into APB transfers on PCLK. It is the requester-side counterpart to the GPIO APB slave. It sits between an on-chip controller or sequencer and the apb_top register interface, so the GPIO can be driven from RTL rather than only from a bench. It handles one outstanding transfer at a time, supports PREADY wait states, enforces a wait-state timeout and rejects misaligned addresses.

---
 rtl/apb_initiator.sv | 153 +++++++++++++++
 tb/tb_apb_initiator.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_initiator.sv
// APB3 initiator: turns a valid/ready command stream into single APB transfers
// with PREADY wait states, a wait-state timeout and misaligned-address rejection.
module apb_initiator #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     wait_cnt_r, wait_cnt_s;
  logic              cmd_ready_r, cmd_ready_s;
  logic              rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_s;
  logic              rsp_err_r, rsp_err_s;
  logic              psel_r, psel_s;
  logic              penable_r, penable_s;
  logic              pwrite_r, pwrite_s;
  logic [ADDR_W-1:0] paddr_r, paddr_s;
  logic [DATA_W-1:0] pwdata_r, pwdata_s;

  // Next-state and next-output logic; every output is the registered copy of these.
  always_comb begin
    state_s     = state_r;
    wait_cnt_s  = wait_cnt_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    pwrite_s    = pwrite_r;
    paddr_s     = paddr_r;
    pwdata_s    = pwdata_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          pwrite_s = cmd_write;
          paddr_s  = cmd_addr;
          pwdata_s = cmd_wdata;
          if (cmd_addr[1:0] != 2'b00) begin
            state_s     = ST_RESP;
            rsp_err_s   = 1'b1;
            rsp_rdata_s = {DATA_W{1'b0}};
          end else begin
            state_s    = ST_SETUP;
            wait_cnt_s = {CW{1'b0}};
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_s     = ST_RESP;
          rsp_err_s   = 1'b0;
          rsp_rdata_s = pwrite_r ? {DATA_W{1'b0}} : PRDATA;
        end else begin
          // wait_cnt_s counts elapsed ACCESS cycles, so the timeout lands after exactly TIMEOUT of them
          wait_cnt_s = wait_cnt_r + CW'(1);
          if ((TIMEOUT != 0) && (wait_cnt_s == TMO_C)) begin
            state_s     = ST_RESP;
            rsp_err_s   = 1'b1;
            rsp_rdata_s = {DATA_W{1'b0}};
          end else begin
            state_s = ST_ACCESS;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    psel_s      = (state_s == ST_SETUP) || (state_s == ST_ACCESS);
    penable_s   = (state_s == ST_ACCESS);
    rsp_valid_s = (state_s == ST_RESP);
    cmd_ready_s = (state_s == ST_IDLE);
  end

  // State, wait counter and output registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= {CW{1'b0}};
      cmd_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
      psel_r      <= 1'b0;
      penable_r   <= 1'b0;
      pwrite_r    <= 1'b0;
      paddr_r     <= {ADDR_W{1'b0}};
      pwdata_r    <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      cmd_ready_r <= cmd_ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      psel_r      <= psel_s;
      penable_r   <= penable_s;
      pwrite_r    <= pwrite_s;
      paddr_r     <= paddr_s;
      pwdata_r    <= pwdata_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign PSEL      = psel_r;
  assign PENABLE   = penable_r;
  assign PWRITE    = pwrite_r;
  assign PADDR     = paddr_r;
  assign PWDATA    = pwdata_r;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed self-checking bench for apb_initiator (default parameters, TIMEOUT = 16)
// with a small word-memory APB slave model.
module tb_apb_initiator;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  logic [31:0] mem [0:15];
  logic        use_mem;
  logic [31:0] prdata_drv;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          prev_cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          acc;

  apb_initiator dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // slave model: completed writes land in a 16-word memory
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;
  end

  assign PRDATA = use_mem ? mem[PADDR[5:2]] : prdata_drv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic ok;
    logic rdy;
    ok = 1'b0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = cmd_ready;
      tick;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    prev_cyc  = acc_cyc;
    acc_cyc   = cyc;
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_access(input int ready_after, input logic [31:0] exp_addr, output int n_acc);
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!PENABLE) break;
      n_acc++;
      chk("acc_paddr", PADDR, exp_addr);
      chk("acc_psel", PSEL, 1'b1);
      PREADY = (ready_after >= 0) && (n_acc > ready_after);
      tick;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    use_mem    = 1'b1;
    prdata_drv = 32'd0;
    PRESETn    = 1'b0;
    cmd_valid  = 1'b1;
    cmd_write  = 1'b1;
    cmd_addr   = 32'h0000_0004;
    cmd_wdata  = 32'h1234_5678;
    rsp_ready  = 1'b1;
    PREADY     = 1'b1;

    // reset held with a pending command
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
    end
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", rsp_err, 1'b0);
    cmd_valid = 1'b0;
    PRESETn   = 1'b1;
    tick;
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    chk("rel_psel", PSEL, 1'b0);

    // zero-wait write
    issue(1'b1, 32'h0000_0004, 32'hAAAA_FFFF);
    chk("wr_setup_psel", PSEL, 1'b1);
    chk("wr_setup_pen", PENABLE, 1'b0);
    chk("wr_paddr", PADDR, 32'h0000_0004);
    chk("wr_pwdata", PWDATA, 32'hAAAA_FFFF);
    chk("wr_pwrite", PWRITE, 1'b1);
    chk("wr_cmd_ready", cmd_ready, 1'b0);
    tick;
    chk("wr_acc_psel", PSEL, 1'b1);
    chk("wr_acc_pen", PENABLE, 1'b1);
    chk("wr_acc_paddr", PADDR, 32'h0000_0004);
    tick;
    chk("wr_rsp_valid", rsp_valid, 1'b1);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_rsp_psel", PSEL, 1'b0);
    tick;
    chk("wr_done_valid", rsp_valid, 1'b0);
    chk("wr_done_ready", cmd_ready, 1'b1);

    // zero-wait read-back, accepted 4 cycles after the write
    issue(1'b0, 32'h0000_0004, 32'h0);
    chk("cmd_spacing", acc_cyc - prev_cyc, 64'd4);
    chk("rd_pwrite", PWRITE, 1'b0);
    tick;
    run_access(0, 32'h0000_0004, acc);
    chk("rd_acc_len", acc, 64'd1);
    chk("rd_rsp_valid", rsp_valid, 1'b1);
    chk("rd_rdata", rsp_rdata, 32'hAAAA_FFFF);
    chk("rd_err", rsp_err, 1'b0);
    tick;

    // three wait states then ready
    use_mem    = 1'b0;
    prdata_drv = 32'hABFE_FABE;
    PREADY     = 1'b0;
    issue(1'b0, 32'h0000_0008, 32'h0);
    tick;
    run_access(3, 32'h0000_0008, acc);
    chk("ws_acc_len", acc, 64'd4);
    chk("ws_rsp_valid", rsp_valid, 1'b1);
    chk("ws_rdata", rsp_rdata, 32'hABFE_FABE);
    chk("ws_err", rsp_err, 1'b0);
    tick;

    // PREADY stuck low: timeout after 16 ACCESS cycles
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0);
    tick;
    run_access(-1, 32'h0000_0010, acc);
    chk("to_acc_len", acc, 64'd16);
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, 32'd0);
    tick;

    // normal write after the timeout
    use_mem = 1'b1;
    PREADY  = 1'b1;
    issue(1'b1, 32'h0000_000C, 32'h1234_5678);
    tick;
    run_access(0, 32'h0000_000C, acc);
    chk("post_to_len", acc, 64'd1);
    chk("post_to_valid", rsp_valid, 1'b1);
    chk("post_to_err", rsp_err, 1'b0);
    tick;

    // misaligned command with response backpressure
    rsp_ready = 1'b0;
    issue(1'b0, 32'h0000_0006, 32'h0);
    chk("mis_valid", rsp_valid, 1'b1);
    chk("mis_err", rsp_err, 1'b1);
    chk("mis_rdata", rsp_rdata, 32'd0);
    chk("mis_paddr", PADDR, 32'h0000_0006);
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_psel", PSEL, 1'b0);
      tick;
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_err", rsp_err, 1'b1);
      chk("bp_rdata", rsp_rdata, 32'd0);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    chk("bp_done_valid", rsp_valid, 1'b0);
    chk("bp_done_ready", cmd_ready, 1'b1);

    // reset during the second ACCESS cycle of a wait-stated read
    PREADY = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0);
    tick;
    chk("mid_acc1", PENABLE, 1'b1);
    tick;
    chk("mid_acc2", PENABLE, 1'b1);
    PRESETn = 1'b0;
    tick;
    chk("mid_rst_psel", PSEL, 1'b0);
    chk("mid_rst_pen", PENABLE, 1'b0);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_paddr", PADDR, 32'd0);
    PRESETn = 1'b1;
    PREADY  = 1'b1;
    tick;
    chk("mid_rel_valid", rsp_valid, 1'b0);
    chk("mid_rel_ready", cmd_ready, 1'b1);
    issue(1'b0, 32'h0000_000C, 32'h0);
    tick;
    run_access(0, 32'h0000_000C, acc);
    chk("mid_post_valid", rsp_valid, 1'b1);
    chk("mid_post_rdata", rsp_rdata, 32'h1234_5678);
    chk("mid_post_err", rsp_err, 1'b0);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
